// File: rtl/array_pkg.sv
// Shared definitions for the systolic-array sequencer.
//   state_t      : FSM state codes, visible on the sequencer's 'state' port
//   CTL_*        : 2-bit control codes carried by every ctlpe/ctlbw/ctlbin field
//   CNT_W        : width of the phase counters
//   sat_inc      : saturating increment used by all phase counters
package array_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_IN = 4'd1,
        ST_LOAD_W  = 4'd2,
        ST_CAL     = 4'd3,
        ST_OUT     = 4'd4,
        ST_WAIT    = 4'd5
    } state_t;

    localparam logic [1:0] CTL_HOLD    = 2'b00;
    localparam logic [1:0] CTL_WRITE   = 2'b01;
    localparam logic [1:0] CTL_COMPUTE = 2'b10;
    localparam logic [1:0] CTL_CLEAR   = 2'b11;

    localparam int unsigned CNT_W = 16;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pe_wavefront_decode.sv
// Diagonal wavefront decode for the PE array during the compute phase.
// PE (r,c) receives CTL_COMPUTE while the compute cycle count lies in
// [r+c, r+c+VECTOR-1]; every other PE holds.
//   enable   : in : compute phase active; all fields hold when low
//   countcal : in : compute cycle index, 0 on the first compute cycle
//   ctlpe    : out: 2-bit field per PE, field (r,c) at bits [2*(r*COLS+c) +: 2]
module pe_wavefront_decode
    import array_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned VECTOR = 4
) (
    input  logic                   enable,
    input  logic [CNT_W-1:0]       countcal,
    output logic [ROWS*COLS*2-1:0] ctlpe
);

    logic [31:0] t;

    assign t = 32'(countcal);

    always_comb begin
        ctlpe = {ROWS*COLS{CTL_HOLD}};
        if (enable) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (t >= r + c && t < r + c + VECTOR) begin
                        ctlpe[2*(r*COLS+c) +: 2] = CTL_COMPUTE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/array_sequencer.sv
// Control sequencer for a ROWS x COLS systolic PE array with per-column input
// buffers and per-row weight buffers. A job loads inputs, optionally reloads
// weights, runs a diagonal compute wavefront, then drains ROWS output beats.
// Ports:
//   clk, rst                 : rising-edge clock, synchronous active-low reset
//   start                    : one-cycle job start, honoured only in IDLE
//   reload_w                 : request weight reload on the next pixel (latched)
//   in/in_valid, w/w_valid   : input and weight word streams (data is not
//                              used here; only the qualifiers advance phases)
//   pixel_finish             : in WAIT, begin the next pixel
//   picture_finish           : in WAIT, end the picture (wins over pixel_finish)
//   out_ready                : downstream accepts an output beat
//   ctlpe/ctlbw/ctlbin       : 2-bit control per PE / weight buffer / input buffer
//   out_valid                : output beat valid
//   state                    : current state code
//   countin/countw/countcal/countpe : saturating phase counters
//   *_finish                 : one-cycle phase-done pulses
//   w_loaded                 : weight buffers hold valid weights
module array_sequencer
    import array_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned VECTOR = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reload_w,
    input  logic [WIDTH-1:0]       in,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       w,
    input  logic                   w_valid,
    input  logic                   pixel_finish,
    input  logic                   picture_finish,
    input  logic                   out_ready,
    output logic [ROWS*COLS*2-1:0] ctlpe,
    output logic [ROWS*2-1:0]      ctlbw,
    output logic [COLS*2-1:0]      ctlbin,
    output logic                   out_valid,
    output logic [3:0]             state,
    output logic [CNT_W-1:0]       countin,
    output logic [CNT_W-1:0]       countw,
    output logic [CNT_W-1:0]       countcal,
    output logic [CNT_W-1:0]       countpe,
    output logic                   loadin_finish,
    output logic                   loadw_finish,
    output logic                   cal_finish,
    output logic                   output_finish,
    output logic                   w_loaded
);

    localparam int unsigned IN_BEATS = COLS * VECTOR;
    localparam int unsigned W_BEATS  = ROWS * VECTOR;
    localparam int unsigned CAL_LAST = VECTOR + ROWS + COLS - 3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] countin_q, countin_d;
    logic [CNT_W-1:0] countw_q, countw_d;
    logic [CNT_W-1:0] countcal_q, countcal_d;
    logic [CNT_W-1:0] countpe_q, countpe_d;
    logic             w_loaded_q, w_loaded_d;
    logic             reload_q, reload_d;
    logic             clear_q, clear_d;
    logic             reload_pend;
    logic             in_cal;
    logic [ROWS*COLS*2-1:0] ctlpe_cal;

    // Data words pass straight to the buffers; the sequencer only needs qualifiers.
    logic data_unused;
    assign data_unused = ^{in, w};

    assign in_cal = (state_q == ST_CAL);

    pe_wavefront_decode #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .VECTOR (VECTOR)
    ) u_wavefront (
        .enable   (in_cal),
        .countcal (countcal_q),
        .ctlpe    (ctlpe_cal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            countin_q  <= '0;
            countw_q   <= '0;
            countcal_q <= '0;
            countpe_q  <= '0;
            w_loaded_q <= 1'b0;
            reload_q   <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            countin_q  <= countin_d;
            countw_q   <= countw_d;
            countcal_q <= countcal_d;
            countpe_q  <= countpe_d;
            w_loaded_q <= w_loaded_d;
            reload_q   <= reload_d;
            clear_q    <= clear_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        countin_d     = countin_q;
        countw_d      = countw_q;
        countcal_d    = countcal_q;
        countpe_d     = countpe_q;
        w_loaded_d    = w_loaded_q;
        // A request arriving in the current cycle counts as already latched.
        reload_pend   = reload_q | reload_w;
        reload_d      = reload_pend;
        clear_d       = 1'b0;
        ctlpe         = {ROWS*COLS{CTL_HOLD}};
        ctlbw         = {ROWS{CTL_HOLD}};
        ctlbin        = {COLS{CTL_HOLD}};
        out_valid     = 1'b0;
        loadin_finish = 1'b0;
        loadw_finish  = 1'b0;
        cal_finish    = 1'b0;
        output_finish = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD_IN;
                    countin_d  = '0;
                    countw_d   = '0;
                    countcal_d = '0;
                    countpe_d  = '0;
                end
            end

            ST_LOAD_IN: begin
                // First cycle after a pixel boundary clears the PE accumulators.
                if (clear_q) begin
                    ctlpe = {ROWS*COLS{CTL_CLEAR}};
                end
                if (in_valid) begin
                    for (int unsigned i = 0; i < COLS; i++) begin
                        if (32'(countin_q) / VECTOR == i) begin
                            ctlbin[2*i +: 2] = CTL_WRITE;
                        end
                    end
                    countin_d = sat_inc(countin_q);
                    if (32'(countin_q) == IN_BEATS - 1) begin
                        loadin_finish = 1'b1;
                        state_d = (!w_loaded_q || reload_pend) ? ST_LOAD_W : ST_CAL;
                    end
                end
            end

            ST_LOAD_W: begin
                if (w_valid) begin
                    for (int unsigned i = 0; i < ROWS; i++) begin
                        if (32'(countw_q) / VECTOR == i) begin
                            ctlbw[2*i +: 2] = CTL_WRITE;
                        end
                    end
                    countw_d = sat_inc(countw_q);
                    if (32'(countw_q) == W_BEATS - 1) begin
                        loadw_finish = 1'b1;
                        w_loaded_d   = 1'b1;
                        reload_d     = 1'b0;
                        state_d      = ST_CAL;
                    end
                end
            end

            ST_CAL: begin
                ctlbin     = {COLS{CTL_COMPUTE}};
                ctlbw      = {ROWS{CTL_COMPUTE}};
                ctlpe      = ctlpe_cal;
                countcal_d = sat_inc(countcal_q);
                if (32'(countcal_q) == CAL_LAST) begin
                    cal_finish = 1'b1;
                    state_d    = ST_OUT;
                end
            end

            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    for (int unsigned r = 0; r < ROWS; r++) begin
                        for (int unsigned c = 0; c < COLS; c++) begin
                            if (32'(countpe_q) == r) begin
                                ctlpe[2*(r*COLS+c) +: 2] = CTL_COMPUTE;
                            end
                        end
                    end
                    countpe_d = sat_inc(countpe_q);
                    if (32'(countpe_q) == ROWS - 1) begin
                        output_finish = 1'b1;
                        state_d       = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (picture_finish) begin
                    state_d    = ST_IDLE;
                    w_loaded_d = 1'b0;
                end else if (pixel_finish) begin
                    state_d    = ST_LOAD_IN;
                    countin_d  = '0;
                    countw_d   = '0;
                    countcal_d = '0;
                    countpe_d  = '0;
                    clear_d    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign state    = state_q;
    assign countin  = countin_q;
    assign countw   = countw_q;
    assign countcal = countcal_q;
    assign countpe  = countpe_q;
    assign w_loaded = w_loaded_q;

endmodule

// File: tb/tb_array_sequencer.sv
// Scoreboard bench for array_sequencer: phase tasks drive randomized stimulus
// and queue the expected per-cycle response; a negedge monitor compares it.
module tb_array_sequencer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned ROWS    = 4;
    localparam int unsigned COLS    = 4;
    localparam int unsigned VECTOR  = 4;
    localparam int unsigned CAL_LEN = VECTOR + ROWS + COLS - 2;

    localparam logic [3:0] S_IDLE = 4'd0, S_LIN = 4'd1, S_LW = 4'd2,
                           S_CAL = 4'd3, S_OUT = 4'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start, reload_w, in_valid, w_valid, pixel_finish, picture_finish, out_ready;
    logic [WIDTH-1:0] in_word, w_word;
    logic [ROWS*COLS*2-1:0] ctlpe;
    logic [ROWS*2-1:0] ctlbw;
    logic [COLS*2-1:0] ctlbin;
    logic out_valid, loadin_finish, loadw_finish, cal_finish, output_finish, w_loaded;
    logic [3:0] state;
    logic [15:0] countin, countw, countcal, countpe;

    array_sequencer #(
        .WIDTH  (WIDTH),
        .ROWS   (ROWS),
        .COLS   (COLS),
        .VECTOR (VECTOR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .reload_w       (reload_w),
        .in             (in_word),
        .in_valid       (in_valid),
        .w              (w_word),
        .w_valid        (w_valid),
        .pixel_finish   (pixel_finish),
        .picture_finish (picture_finish),
        .out_ready      (out_ready),
        .ctlpe          (ctlpe),
        .ctlbw          (ctlbw),
        .ctlbin         (ctlbin),
        .out_valid      (out_valid),
        .state          (state),
        .countin        (countin),
        .countw         (countw),
        .countcal       (countcal),
        .countpe        (countpe),
        .loadin_finish  (loadin_finish),
        .loadw_finish   (loadw_finish),
        .cal_finish     (cal_finish),
        .output_finish  (output_finish),
        .w_loaded       (w_loaded)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned            cyc;
        logic [3:0]             state;
        logic [ROWS*COLS*2-1:0] ctlpe;
        logic [ROWS*2-1:0]      ctlbw;
        logic [COLS*2-1:0]      ctlbin;
        logic [3:0]             fin;   // {output, cal, loadw, loadin}
        logic                   ov;
        logic                   wl;
        logic [15:0]            cin, cw, ccal, cpe;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference model of job-level state.
    logic [15:0] cin, cw, ccal, cpe;
    bit wl_m = 1'b0;
    bit rl_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] st);
        exp_t e;
        e.cyc = cyc; e.state = st; e.ctlpe = '0; e.ctlbw = '0; e.ctlbin = '0;
        e.fin = '0; e.ov = 1'b0; e.wl = wl_m;
        e.cin = cin; e.cw = cw; e.ccal = ccal; e.cpe = cpe;
        return e;
    endfunction

    task automatic push(input exp_t e);
        if (e.ov || e.ctlpe != '0 || e.ctlbw != '0 || e.ctlbin != '0 || e.fin != '0)
            q.push_back(e);
    endtask

    // Monitor: any visible activity must match the front of the scoreboard.
    exp_t m_e;
    logic m_ev, m_due;
    always @(negedge clk) begin
        if (mon_en) begin
            m_ev  = out_valid || (ctlpe != '0) || (ctlbw != '0) || (ctlbin != '0) ||
                    loadin_finish || loadw_finish || cal_finish || output_finish;
            m_due = (q.size() != 0) && (q[0].cyc == cyc);
            if (m_due) begin
                m_e = q.pop_front();
                check("state", 64'(state), 64'(m_e.state));
                check("ctl_pe_bw_bin", 64'({ctlpe, ctlbw, ctlbin}),
                      64'({m_e.ctlpe, m_e.ctlbw, m_e.ctlbin}));
                check("finish_ov_wl",
                      64'({output_finish, cal_finish, loadw_finish, loadin_finish, out_valid, w_loaded}),
                      64'({m_e.fin, m_e.ov, m_e.wl}));
                check("counters", {countin, countw, countcal, countpe},
                      {m_e.cin, m_e.cw, m_e.ccal, m_e.cpe});
            end else if (m_ev) begin
                check("unexpected_output",
                      64'({out_valid, output_finish, cal_finish, loadw_finish, loadin_finish,
                           ctlbw, ctlbin, ctlpe}), 64'(0));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start = 1'b0; reload_w = 1'b0; in_valid = 1'b0; w_valid = 1'b0;
        pixel_finish = 1'b0; picture_finish = 1'b0; out_ready = 1'b0;
        in_word = WIDTH'($urandom); w_word = WIDTH'($urandom);
    endtask

    task automatic zero_model_counters();
        cin = '0; cw = '0; ccal = '0; cpe = '0;
    endtask

    task automatic start_job();
        next_cycle(); drive_idle();
        rst = 1'b1; start = 1'b1;
        zero_model_counters();
    endtask

    // mode: 0 alternate valid/invalid, 1 always valid, 2 random
    task automatic do_load_in(input bit clr, input int mode);
        exp_t e;
        int k = 0;
        int n = 0;
        bit v;
        while (k < int'(COLS*VECTOR)) begin
            next_cycle(); drive_idle();
            start = 1'($urandom_range(0, 1));
            v = (mode == 0) ? (n % 2 == 0) : (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_valid = v;
            e = mk(S_LIN);
            e.cin = 16'(k);
            if (clr && n == 0) e.ctlpe = '1;
            if (v) e.ctlbin[2*(k/int'(VECTOR)) +: 2] = 2'b01;
            e.fin[0] = v && (k == int'(COLS*VECTOR) - 1);
            push(e);
            if (v) k++;
            n++;
        end
        cin = 16'(k);
    endtask

    task automatic do_load_w(input int mode);
        exp_t e;
        int k = 0;
        bit v;
        while (k < int'(ROWS*VECTOR)) begin
            next_cycle(); drive_idle();
            start = 1'($urandom_range(0, 1));
            v = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            w_valid = v;
            e = mk(S_LW);
            e.cw = 16'(k);
            if (v) e.ctlbw[2*(k/int'(VECTOR)) +: 2] = 2'b01;
            e.fin[1] = v && (k == int'(ROWS*VECTOR) - 1);
            push(e);
            if (v) k++;
        end
        cw = 16'(k);
        wl_m = 1'b1;
        rl_m = 1'b0;
    endtask

    // stop_at >= 0 pulls reset low in that compute cycle.
    task automatic do_cal(input int stop_at, input bit rnd_reload);
        exp_t e;
        int d;
        for (int t = 0; t < int'(CAL_LEN); t++) begin
            next_cycle(); drive_idle();
            start = 1'($urandom_range(0, 1));
            reload_w = rnd_reload && ($urandom_range(0, 7) == 0);
            if (reload_w) rl_m = 1'b1;
            e = mk(S_CAL);
            e.ccal = 16'(t);
            e.ctlbw = {ROWS{2'b10}};
            e.ctlbin = {COLS{2'b10}};
            for (int r = 0; r < int'(ROWS); r++)
                for (int c = 0; c < int'(COLS); c++) begin
                    d = t - (r + c);
                    if (d >= 0 && d < int'(VECTOR)) e.ctlpe[2*(r*int'(COLS)+c) +: 2] = 2'b10;
                end
            e.fin[2] = (t == int'(CAL_LEN) - 1);
            if (t == stop_at) rst = 1'b0;
            push(e);
            if (t == stop_at) return;
        end
        ccal = 16'(CAL_LEN);
    endtask

    task automatic do_out(input int stall);
        exp_t e;
        int b = 0;
        int s = stall;
        while (b < int'(ROWS)) begin
            next_cycle(); drive_idle();
            start = 1'($urandom_range(0, 1));
            if (s > 0) begin
                out_ready = 1'b0;
                s--;
            end else begin
                out_ready = (stall > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            e = mk(S_OUT);
            e.ov = 1'b1;
            e.cpe = 16'(b);
            if (out_ready) begin
                for (int c = 0; c < int'(COLS); c++) e.ctlpe[2*(b*int'(COLS)+c) +: 2] = 2'b10;
                e.fin[3] = (b == int'(ROWS) - 1);
            end
            push(e);
            if (out_ready) b++;
        end
        cpe = 16'(ROWS);
    endtask

    task automatic finish_pixel(input int w_mode, input int stall, input bit rnd_reload);
        if (!wl_m || rl_m) do_load_w(w_mode);
        do_cal(-1, rnd_reload);
        do_out(stall);
    endtask

    // action: 0 pixel_finish, 1 picture_finish, 2 both
    task automatic do_wait(input int idle_n, input bit reload, input int action);
        for (int i = 0; i < idle_n; i++) begin
            next_cycle(); drive_idle();
            start = 1'($urandom_range(0, 1));
        end
        if (reload) begin
            next_cycle(); drive_idle();
            reload_w = 1'b1;
            rl_m = 1'b1;
        end
        next_cycle(); drive_idle();
        start = 1'($urandom_range(0, 1));
        pixel_finish = (action != 1);
        picture_finish = (action != 0);
        if (action == 0) zero_model_counters();
        else wl_m = 1'b0;
    endtask

    task automatic idle_check();
        next_cycle(); drive_idle();
        check("idle_state_after_picture", 64'(state), 64'(S_IDLE));
        check("w_loaded_after_picture", 64'(w_loaded), 64'(wl_m));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_state"}, 64'(state), 64'(S_IDLE));
        check({name, "_counters"}, {countin, countw, countcal, countpe}, 64'(0));
        check({name, "_ctl"}, 64'({ctlpe, ctlbw, ctlbin}), 64'(0));
        check({name, "_flags"},
              64'({out_valid, w_loaded, loadin_finish, loadw_finish, cal_finish, output_finish}),
              64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no $finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        drive_idle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        check_all_zero("reset");
        mon_en = 1'b1;

        // Job 1: alternating input beats, fresh weights, output stalled 3 cycles.
        start_job();
        do_load_in(1'b0, 0);
        finish_pixel(1, 3, 1'b0);
        do_wait(1, 1'b0, 0);
        // Pixel 2: weights held, straight to compute.
        do_load_in(1'b1, 1);
        finish_pixel(2, 0, 1'b0);
        do_wait(0, 1'b1, 0);
        // Pixel 3: reload requested, weights reloaded; end with both pulses.
        do_load_in(1'b1, 2);
        finish_pixel(2, 0, 1'b0);
        do_wait(2, 1'b0, 2);
        idle_check();

        // Randomized jobs.
        for (int j = 0; j < 3; j++) begin
            start_job();
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                do_load_in(p > 0, 2);
                finish_pixel(2, $urandom_range(0, 2), 1'b1);
                if (p == np - 1) do_wait($urandom_range(0, 2), 1'b0, $urandom_range(1, 2));
                else do_wait($urandom_range(0, 2), ($urandom_range(0, 2) == 0), 0);
            end
            idle_check();
        end

        // Reset in the middle of compute.
        start_job();
        do_load_in(1'b0, 1);
        do_load_w(1);
        do_cal(5, 1'b0);
        next_cycle(); drive_idle();
        rst = 1'b1;
        check_all_zero("midcal_reset");
        wl_m = 1'b0; rl_m = 1'b0;
        zero_model_counters();

        // A full job after the reset.
        start_job();
        do_load_in(1'b0, 2);
        finish_pixel(2, 1, 1'b0);
        do_wait(0, 1'b0, 1);
        idle_check();

        repeat (3) next_cycle();
        check("scoreboard_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
